// File: rtl/pdp8_tt_pkg.sv
// ============================================================================
// pdp8_tt_pkg : shared constants for the PDP-8 console (major states, IOT ops)
// Revision 1.0
// ============================================================================
`default_nettype none

package pdp8_tt_pkg;

  localparam logic [3:0] F0 = 4'b0000;
  localparam logic [3:0] F1 = 4'b0001;
  localparam logic [3:0] F2 = 4'b0010;
  localparam logic [3:0] F3 = 4'b0011;

  localparam logic [2:0] OP_SKIP = 3'b001;
  localparam logic [2:0] OP_CLR  = 3'b010;
  localparam logic [2:0] OP_RD   = 3'b100;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_RB   = 3'b110;
  localparam logic [2:0] OP_LS   = 3'b110;
  localparam logic [2:0] OP_IE   = 3'b101;
  localparam logic [2:0] OP_SK   = 3'b101;

  localparam logic [5:0] KBD_DEV_DEFAULT = 6'o03;
  localparam logic [5:0] TTY_DEV_DEFAULT = 6'o04;

endpackage

`default_nettype wire

// File: rtl/pdp8_sync_fifo.sv
// ============================================================================
// pdp8_sync_fifo : single-clock FIFO, depth 2**AW, head reads 0 when empty
// Revision 1.0
// ============================================================================
`default_nettype none

module pdp8_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra pointer bit distinguishes full from empty when the indices meet.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/pdp8_tt_fifo.sv
// ============================================================================
// pdp8_tt_fifo : KL8-style console, IOT decode plus RX/TX byte-stream FIFOs
// Revision 1.0
// ============================================================================
`default_nettype none

module pdp8_tt_fifo
  import pdp8_tt_pkg::*;
#(
  parameter logic [5:0] KBD_DEV  = KBD_DEV_DEFAULT,
  parameter logic [5:0] TTY_DEV  = TTY_DEV_DEFAULT,
  parameter int         RX_AW    = 2,
  parameter int         TX_AW    = 2,
  parameter int         STRIP_B7 = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [11:0] io_data_in,
  input  logic [5:0]  io_select,
  output logic [11:0] io_data_out,
  output logic        io_selected,
  output logic        io_data_avail,
  output logic        io_interrupt,
  output logic        io_skip,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_ovf
);

  logic       f1_now, prev_f1, first_f1;
  logic       kbd_sel, tty_sel;
  logic [2:0] op;
  logic       rx_pop, tx_push, tx_clr, ie_wr;
  logic       tx_flag, ie;
  logic [7:0] rx_head, rx_wdata;
  logic       rx_empty, rx_full, rx_flag;
  logic       tx_empty, tx_full, tx_hs;
  logic       unused_mb;

  assign unused_mb = &{1'b0, mb[11:3]};

  assign f1_now   = iot && (state == F1);
  assign first_f1 = f1_now && !prev_f1;
  assign kbd_sel  = f1_now && (io_select == KBD_DEV);
  assign tty_sel  = f1_now && (io_select == TTY_DEV);
  assign op       = mb[2:0];

  assign rx_flag       = !rx_empty;
  assign rx_ready      = !rx_full;
  assign rx_wdata      = (STRIP_B7 != 0) ? {1'b0, rx_data[6:0]} : rx_data;
  assign tx_valid      = !tx_empty;
  assign tx_hs         = tx_valid && tx_ready;
  assign io_selected   = kbd_sel || tty_sel;
  assign io_data_avail = 1'b1;
  assign io_interrupt  = ie && (rx_flag || tx_flag);

  // Side-effect strobes only fire on the first F1 cycle of an IOT.
  always_comb begin
    io_skip     = 1'b0;
    io_data_out = io_data_in;
    rx_pop      = 1'b0;
    tx_push     = 1'b0;
    tx_clr      = 1'b0;
    ie_wr       = 1'b0;
    if (kbd_sel) begin
      case (op)
        OP_SKIP: io_skip = rx_flag;
        OP_CLR: begin
          io_data_out = '0;
          rx_pop      = first_f1;
        end
        OP_RD:   io_data_out = {4'b0000, rx_head};
        OP_RB: begin
          io_data_out = {4'b0000, rx_head};
          rx_pop      = first_f1;
        end
        OP_IE:   ie_wr = first_f1;
        default: ;
      endcase
    end else if (tty_sel) begin
      case (op)
        OP_SKIP: io_skip = tx_flag;
        OP_CLR:  tx_clr  = first_f1;
        OP_LD:   tx_push = first_f1;
        OP_LS: begin
          tx_clr  = first_f1;
          tx_push = first_f1;
        end
        OP_SK:   io_skip = rx_flag || tx_flag;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_f1 <= 1'b0;
      tx_flag <= 1'b0;
      ie      <= 1'b1;
      tx_ovf  <= 1'b0;
    end else begin
      prev_f1 <= f1_now;
      if (tx_hs)       tx_flag <= 1'b1;
      else if (tx_clr) tx_flag <= 1'b0;
      if (ie_wr) ie <= io_data_in[0];
      if (tx_push && tx_full) tx_ovf <= 1'b1;
    end
  end

  pdp8_sync_fifo #(.W(8), .AW(RX_AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid && rx_ready),
    .din   (rx_wdata),
    .pop   (rx_pop),
    .head  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  pdp8_sync_fifo #(.W(8), .AW(TX_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (io_data_in[7:0]),
    .pop   (tx_hs),
    .head  (tx_data),
    .empty (tx_empty),
    .full  (tx_full)
  );

endmodule

`default_nettype wire
